pps_slice_demux: RTL and testbench
==================================

// Module: pps_slice_demux
// PURPOSE
// Single-clock stage directly downstream of the decoder input clock-crossing buffer. Splits the
// buffered input word stream into two outputs:
//   - a captured Picture Parameter Set (PPS) for the decoder configuration logic;
//   - a slice-data word stream for the bitstream parser.
// Slice data is forwarded only after a complete, well-formed PPS has been locked.
// PARAMETERS
// DATA_WIDTH   256   width of input/output data words
// PPS_BYTES    128   PPS size in bytes; PPS_WORDS = PPS_BYTES*8/DATA_WIDTH (integer, >=1; 4 by default)
// PORTS
// clk             in   1             decoder core clock
// rst_n           in   1             asynchronous active-low reset
// flush           in   1             synchronous flush, returns block to reset state
// in_data         in   DATA_WIDTH    input word
// in_valid        in   1             in_data valid this cycle (no backpressure exists)
// in_sof          in   1             first slice word of frame (qualified by in_valid)
// in_eof          in   1             last slice word of frame (qualified by in_valid)
// in_data_is_pps  in   1             word belongs to PPS (qualified by in_valid)
// pps             out  PPS_BYTES*8   locked PPS; byte 0 in bits [PPS_BYTES*8-1 -: 8]
// pps_valid       out  1             one-cycle pulse when a new PPS is committed
// pps_locked      out  1             a complete PPS is held and slice data is forwarded
// pps_error       out  1             sticky: PPS sequence was truncated
// out_data        out  DATA_WIDTH    slice word
// out_valid       out  1             out_data valid
// out_sof, out_eof out 1 each        frame markers aligned to out_valid
// drop_cnt        out  16            saturating count of slice words dropped while unlocked
// BEHAVIOUR
// - Reset/flush: all outputs 0, pps = 0, state IDLE, word index 0. flush wins over in_valid the same cycle; that word is discarded.
// - States:
//   - IDLE: no PPS held.
//   - CAPTURE: collecting PPS words.
//   - LOCKED: PPS held, forwarding slice data.
// - PPS word (in_valid & in_data_is_pps) in IDLE or LOCKED:
//   - Start capture: store at index 0, go to CAPTURE.
//   - pps_locked <= 0 the next cycle; pps_error <= 0.
//   - pps keeps its old value.
// - CAPTURE, PPS word at index k: stored in staging register slot k. Word k maps to staging bits
//   [PPS_BYTES*8-1-k*DATA_WIDTH -: DATA_WIDTH]. Index increments.
// - CAPTURE, word at index PPS_WORDS-1: on the next cycle,
//   - staging is copied atomically to pps;
//   - pps_valid = 1 for exactly one cycle;
//   - pps_locked = 1;
//   - state = LOCKED.
//   For PPS_WORDS=1, the first word completes the capture directly.
// - CAPTURE, non-PPS valid word arrives: abort. That word is dropped (drop_cnt +1). pps_error <= 1,
//   state IDLE, pps unchanged, pps_locked stays 0.
// - LOCKED, non-PPS valid word: forwarded with 1-cycle latency.
//   - out_data/out_sof/out_eof are registered copies of the inputs; out_valid = 1.
//   - When forwarding is not happening, out_valid/out_sof/out_eof = 0 and out_data holds.
// - IDLE, non-PPS valid word: dropped. drop_cnt increments and saturates at 16'hFFFF.
// - in_sof/in_eof on PPS words are ignored.
// - No sof/eof consistency checking; the parser owns that.
// - Invalid cycles (in_valid = 0) never change state, index, or staging.
// - Reset asserted mid-capture: immediate clear. Capture restarts only on a new PPS word.
// TESTING
// 1. 4 PPS words carrying bytes 8'h00..8'h7F ->
//    - one cycle after the 4th word: pps_valid pulse for 1 cycle;
//    - pps[1023:1016]=8'h00, pps[7:0]=8'h7F, pps_locked=1.
// 2. After test 1, 3 slice words D0,D1,D2 with sof on D0, eof on D2 ->
//    out_valid on 3 consecutive cycles, 1 cycle late; out_sof only with D0, out_eof only with D2.
// 3. After reset, 3 slice words, then 4 PPS words ->
//    drop_cnt=3, no out_valid, pps_locked rises only after the 4th PPS word.
// 4. 2 PPS words, then 1 slice word ->
//    pps_error=1, pps_locked=0, pps still 0, drop_cnt=1, no out_valid.
// 5. Locked with PPS A; send 4-word PPS B ->
//    - pps_locked=0 from the cycle after B word 0; pps==A until the commit;
//    - then pps==B and pps_valid pulses.
//    A slice word sent mid-B -> pps_error=1, state IDLE.
// 6. flush asserted together with the 3rd PPS word ->
//    all outputs 0 next cycle; a following 4-word PPS locks normally.

Source files
------------

// File: rtl/pps_slice_demux.sv
// Splits the post-CDC word stream into a locked Picture Parameter Set and a slice-data stream.
// Slice data is forwarded only while a complete PPS is held.
module pps_slice_demux #(
    parameter int DATA_WIDTH = 256,
    parameter int PPS_BYTES  = 128
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_valid,
    input  logic                   in_sof,
    input  logic                   in_eof,
    input  logic                   in_data_is_pps,
    output logic [PPS_BYTES*8-1:0] pps,
    output logic                   pps_valid,
    output logic                   pps_locked,
    output logic                   pps_error,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    output logic                   out_sof,
    output logic                   out_eof,
    output logic [15:0]            drop_cnt
);

    localparam int PPS_BITS  = PPS_BYTES * 8;
    localparam int PPS_WORDS = PPS_BITS / DATA_WIDTH;
    localparam int IDX_W     = (PPS_WORDS > 1) ? $clog2(PPS_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PPS_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_LOCKED
    } state_e;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [IDX_W-1:0]      wr_idx;
    logic [PPS_BITS-1:0]   staging_q, staging_d;
    logic [PPS_BITS-1:0]   pps_q, pps_d;
    logic                  pps_valid_q, pps_valid_d;
    logic                  pps_locked_q, pps_locked_d;
    logic                  pps_error_q, pps_error_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_sof_q, out_sof_d;
    logic                  out_eof_q, out_eof_d;
    logic [15:0]           drop_cnt_q, drop_cnt_d;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        staging_d    = staging_q;
        pps_d        = pps_q;
        pps_valid_d  = 1'b0;
        pps_locked_d = pps_locked_q;
        pps_error_d  = pps_error_q;
        out_data_d   = out_data_q;
        out_valid_d  = 1'b0;
        out_sof_d    = 1'b0;
        out_eof_d    = 1'b0;
        drop_cnt_d   = drop_cnt_q;
        // A PPS word outside CAPTURE always restarts the capture at slot 0.
        wr_idx       = (state_q == ST_CAPTURE) ? idx_q : '0;

        if (flush) begin
            state_d      = ST_IDLE;
            idx_d        = '0;
            staging_d    = '0;
            pps_d        = '0;
            pps_locked_d = 1'b0;
            pps_error_d  = 1'b0;
            out_data_d   = '0;
            drop_cnt_d   = '0;
        end else if (in_valid) begin
            if (in_data_is_pps) begin
                for (int k = 0; k < PPS_WORDS; k++) begin
                    if (wr_idx == IDX_W'(k)) begin
                        staging_d[PPS_BITS-1-k*DATA_WIDTH -: DATA_WIDTH] = in_data;
                    end
                end
                if (state_q != ST_CAPTURE) begin
                    pps_locked_d = 1'b0;
                    pps_error_d  = 1'b0;
                end
                if (wr_idx == LAST_IDX) begin
                    pps_d        = staging_d;
                    pps_valid_d  = 1'b1;
                    pps_locked_d = 1'b1;
                    state_d      = ST_LOCKED;
                    idx_d        = '0;
                end else begin
                    state_d      = ST_CAPTURE;
                    idx_d        = wr_idx + 1'b1;
                end
            end else if (state_q == ST_LOCKED) begin
                out_data_d  = in_data;
                out_valid_d = 1'b1;
                out_sof_d   = in_sof;
                out_eof_d   = in_eof;
            end else begin
                if (drop_cnt_q != 16'hFFFF) begin
                    drop_cnt_d = drop_cnt_q + 16'd1;
                end
                // A slice word interrupting a capture means the PPS was truncated.
                if (state_q == ST_CAPTURE) begin
                    pps_error_d = 1'b1;
                    state_d     = ST_IDLE;
                    idx_d       = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            staging_q    <= '0;
            pps_q        <= '0;
            pps_valid_q  <= 1'b0;
            pps_locked_q <= 1'b0;
            pps_error_q  <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_sof_q    <= 1'b0;
            out_eof_q    <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            staging_q    <= staging_d;
            pps_q        <= pps_d;
            pps_valid_q  <= pps_valid_d;
            pps_locked_q <= pps_locked_d;
            pps_error_q  <= pps_error_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_sof_q    <= out_sof_d;
            out_eof_q    <= out_eof_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign pps        = pps_q;
    assign pps_valid  = pps_valid_q;
    assign pps_locked = pps_locked_q;
    assign pps_error  = pps_error_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_sof    = out_sof_q;
    assign out_eof    = out_eof_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_pps_slice_demux.sv
// Self-checking bench for pps_slice_demux: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based model of PPS capture and slice forwarding.
module tb_pps_slice_demux;

    localparam int DW        = 256;
    localparam int PB        = 128;
    localparam int PPS_BITS  = PB * 8;
    localparam int PPS_WORDS = PPS_BITS / DW;

    logic                clk;
    logic                rst_n;
    logic                flush;
    logic [DW-1:0]       in_data;
    logic                in_valid;
    logic                in_sof;
    logic                in_eof;
    logic                in_data_is_pps;
    logic [PPS_BITS-1:0] pps;
    logic                pps_valid;
    logic                pps_locked;
    logic                pps_error;
    logic [DW-1:0]       out_data;
    logic                out_valid;
    logic                out_sof;
    logic                out_eof;
    logic [15:0]         drop_cnt;

    pps_slice_demux #(.DATA_WIDTH(DW), .PPS_BYTES(PB)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof), .in_eof(in_eof),
        .in_data_is_pps(in_data_is_pps),
        .pps(pps), .pps_valid(pps_valid), .pps_locked(pps_locked), .pps_error(pps_error),
        .out_data(out_data), .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof),
        .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int testsRun = 0;
    int testsFailed = 0;
    bit chkEn = 1'b0;

    // Model: spec-level mode plus the list of PPS words gathered so far.
    int                  mMode;
    logic [DW-1:0]       mWords[$];
    logic [PPS_BITS-1:0] expPps;
    logic                expPpsValid, expLocked, expError, expOutValid, expSof, expEof;
    logic [DW-1:0]       expOutData;
    logic [15:0]         expDrop;

    task automatic modelClear();
        mMode = 0;
        mWords.delete();
        expPps = '0; expPpsValid = 0; expLocked = 0; expError = 0;
        expOutValid = 0; expSof = 0; expEof = 0; expOutData = '0; expDrop = '0;
    endtask

    task automatic modelStep();
        expPpsValid = 0; expOutValid = 0; expSof = 0; expEof = 0;
        if (flush) begin
            modelClear();
        end else if (in_valid) begin
            if (in_data_is_pps) begin
                if (mMode != 1) begin
                    mWords.delete();
                    expLocked = 0;
                    expError = 0;
                end
                mWords.push_back(in_data);
                if (mWords.size() == PPS_WORDS) begin
                    expPps = '0;
                    foreach (mWords[i]) expPps = (expPps << DW) | PPS_BITS'(mWords[i]);
                    expPpsValid = 1; expLocked = 1; mMode = 2;
                    mWords.delete();
                end else begin
                    mMode = 1;
                end
            end else if (mMode == 2) begin
                expOutValid = 1; expOutData = in_data; expSof = in_sof; expEof = in_eof;
            end else begin
                if (expDrop != 16'hFFFF) expDrop = expDrop + 16'd1;
                if (mMode == 1) begin
                    expError = 1;
                    mMode = 0;
                    mWords.delete();
                end
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkWide(input string name, input logic [PPS_BITS-1:0] actual, input logic [PPS_BITS-1:0] expected);
        int firstByte;
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            firstByte = 0;
            for (int b = PB - 1; b >= 0; b--) begin
                if (actual[b*8 +: 8] !== expected[b*8 +: 8]) firstByte = PB - 1 - b;
            end
            $display("[TB] FAIL %s: byte %0d got %h expected %h at %0t", name, firstByte,
                     actual[PPS_BITS-1-firstByte*8 -: 8], expected[PPS_BITS-1-firstByte*8 -: 8], $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && chkEn) begin
                checkWide("pps", pps, expPps);
                checkOutput("pps_valid", 64'(pps_valid), 64'(expPpsValid));
                checkOutput("pps_locked", 64'(pps_locked), 64'(expLocked));
                checkOutput("pps_error", 64'(pps_error), 64'(expError));
                checkOutput("out_valid", 64'(out_valid), 64'(expOutValid));
                checkOutput("out_sof", 64'(out_sof), 64'(expSof));
                checkOutput("out_eof", 64'(out_eof), 64'(expEof));
                checkOutput("out_data_lo", out_data[63:0], expOutData[63:0]);
                checkOutput("out_data_hi", out_data[DW-1 -: 64], expOutData[DW-1 -: 64]);
                checkOutput("drop_cnt", 64'(drop_cnt), 64'(expDrop));
            end
        end
    end

    // One cycle of stimulus; returns 1 time unit after the capturing edge.
    task automatic applyStimulus(input logic v, input logic isPps, input logic sof, input logic eof,
                                 input logic [DW-1:0] data, input logic fl);
        in_valid = v; in_data_is_pps = isPps; in_sof = sof; in_eof = eof; in_data = data; flush = fl;
        @(posedge clk);
        if (rst_n) modelStep();
        #1;
        in_valid = 0; in_data_is_pps = 0; in_sof = 0; in_eof = 0; flush = 0;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        #1;
        modelClear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [DW-1:0] randWord();
        logic [DW-1:0] w = '0;
        for (int i = 0; i < DW / 32; i++) w = {w[DW-33:0], 32'($urandom())};
        return w;
    endfunction

    function automatic logic [DW-1:0] byteWord(input int k);
        logic [DW-1:0] w = '0;
        for (int b = 0; b < DW / 8; b++) w = {w[DW-9:0], 8'(k * (DW / 8) + b)};
        return w;
    endfunction

    logic [PPS_BITS-1:0] ppsA, ppsB;
    logic [DW-1:0]       wordsB[PPS_WORDS];

    initial begin
        rst_n = 1'b0; flush = 0; in_valid = 0; in_data_is_pps = 0; in_sof = 0; in_eof = 0; in_data = '0;
        modelClear();
        #12;
        rst_n = 1'b1;
        chkEn = 1'b1;
        checkOutput("reset_locked", 64'(pps_locked), 64'd0);
        checkOutput("reset_drop", 64'(drop_cnt), 64'd0);

        // Bytes 0x00..0x7F across four PPS words.
        for (int k = 0; k < PPS_WORDS; k++) applyStimulus(1, 1, 0, 0, byteWord(k), 0);
        checkOutput("t1_valid", 64'(pps_valid), 64'd1);
        checkOutput("t1_byte0", 64'(pps[1023:1016]), 64'h00);
        checkOutput("t1_byte127", 64'(pps[7:0]), 64'h7F);
        checkOutput("t1_model_byte127", 64'(expPps[7:0]), 64'h7F);
        checkOutput("t1_locked", 64'(pps_locked), 64'd1);
        applyStimulus(0, 0, 0, 0, '0, 0);
        checkOutput("t1_valid_pulse", 64'(pps_valid), 64'd0);

        // Forwarding with frame markers.
        applyStimulus(1, 0, 1, 0, 256'hD0, 0);
        checkOutput("t2_d0_sof", {62'd0, out_valid, out_sof}, 64'd3);
        checkOutput("t2_d0_data", out_data[63:0], 64'hD0);
        applyStimulus(1, 0, 0, 0, 256'hD1, 0);
        checkOutput("t2_d1_flags", {61'd0, out_valid, out_sof, out_eof}, 64'd4);
        applyStimulus(1, 0, 0, 1, 256'hD2, 0);
        checkOutput("t2_d2_eof", {61'd0, out_valid, out_sof, out_eof}, 64'd5);
        applyStimulus(0, 0, 0, 0, '0, 0);
        checkOutput("t2_idle", 64'(out_valid), 64'd0);

        // Drops while unlocked, then capture.
        applyReset();
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, randWord(), 0);
        checkOutput("t3_drop", 64'(drop_cnt), 64'd3);
        for (int k = 0; k < PPS_WORDS; k++) begin
            checkOutput("t3_not_locked", 64'(pps_locked), 64'd0);
            applyStimulus(1, 1, 0, 0, randWord(), 0);
        end
        checkOutput("t3_locked", 64'(pps_locked), 64'd1);

        // Truncated PPS.
        applyReset();
        applyStimulus(1, 1, 0, 0, randWord(), 0);
        applyStimulus(1, 1, 0, 0, randWord(), 0);
        applyStimulus(1, 0, 1, 0, randWord(), 0);
        checkOutput("t4_error", 64'(pps_error), 64'd1);
        checkOutput("t4_locked", 64'(pps_locked), 64'd0);
        checkOutput("t4_drop", 64'(drop_cnt), 64'd1);
        checkWide("t4_pps_zero", pps, '0);

        // Replacing PPS A with PPS B, then a truncated PPS.
        for (int k = 0; k < PPS_WORDS; k++) applyStimulus(1, 1, 0, 0, randWord(), 0);
        ppsA = pps;
        checkWide("t5_model_a", expPps, ppsA);
        for (int k = 0; k < PPS_WORDS; k++) wordsB[k] = randWord();
        ppsB = {wordsB[0], wordsB[1], wordsB[2], wordsB[3]};
        applyStimulus(1, 1, 0, 0, wordsB[0], 0);
        checkOutput("t5_unlock", 64'(pps_locked), 64'd0);
        for (int k = 1; k < PPS_WORDS; k++) begin
            checkWide("t5_hold_a", pps, ppsA);
            applyStimulus(1, 1, 0, 0, wordsB[k], 0);
        end
        checkWide("t5_pps_b", pps, ppsB);
        checkOutput("t5_valid", 64'(pps_valid), 64'd1);
        applyStimulus(1, 1, 0, 0, randWord(), 0);
        applyStimulus(1, 0, 0, 0, randWord(), 0);
        checkOutput("t5_error", 64'(pps_error), 64'd1);
        checkWide("t5_keep_b", pps, ppsB);

        // Flush during capture, then a clean lock.
        applyStimulus(1, 1, 0, 0, randWord(), 0);
        applyStimulus(1, 1, 0, 0, randWord(), 0);
        applyStimulus(1, 1, 0, 0, randWord(), 1);
        checkOutput("t6_flags", {59'd0, pps_valid, pps_locked, pps_error, out_valid, out_sof}, 64'd0);
        checkOutput("t6_drop", 64'(drop_cnt), 64'd0);
        checkWide("t6_pps", pps, '0);
        for (int k = 0; k < PPS_WORDS; k++) applyStimulus(1, 1, 0, 0, randWord(), 0);
        checkOutput("t6_locked", 64'(pps_locked), 64'd1);

        // Randomized traffic.
        for (int it = 0; it < 600; it++) begin
            int r = int'($urandom_range(0, 99));
            if (r < 18) begin
                int n = int'($urandom_range(1, PPS_WORDS));
                for (int k = 0; k < n; k++) begin
                    if ($urandom_range(0, 3) == 0) applyStimulus(0, 1, 1, 1, randWord(), 0);
                    applyStimulus(1, 1, 1'($urandom()), 1'($urandom()), randWord(), 0);
                end
            end else if (r < 21) begin
                applyStimulus(1'($urandom()), 1'($urandom()), 0, 0, randWord(), 1);
            end else if (r < 22) begin
                applyReset();
            end else if (r < 32) begin
                applyStimulus(0, 1'($urandom()), 1'($urandom()), 1'($urandom()), randWord(), 0);
            end else begin
                applyStimulus(1, 0, 1'($urandom()), 1'($urandom()), randWord(), 0);
            end
        end
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
